cdb_broadcaster: RTL and testbench

- Transmit end of the common data bus: collects completed results from the functional units and broadcasts them on the 4-lane CDB that reservation stations and the ROB snoop.
- Each functional unit pushes (rob index, result) through a valid/ready handshake into a private 2-entry FIFO.
- A round-robin arbiter grants up to NUM_LANES sources per cycle onto registered CDB lanes.
- Sits between functional-unit writeback stages and every CDB consumer.

---
 rtl/ooo_pkg.sv | 15 +
 rtl/cdb_src_fifo.sv | 67 ++++++
 rtl/cdb_broadcaster.sv | 100 ++++++++++
 tb/tb_cdb_broadcaster.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: CDB geometry and the lane record
// that the broadcaster drives and every CDB consumer snoops.
package ooo_pkg;

  localparam int ROB_IDX_W = 4;
  localparam int DATA_W    = 16;
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_index;
    logic [DATA_W-1:0]    result;
  } cdb_lane_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Small per-source result FIFO: push/pop/flush with registered count.
// ready_o depends only on the registered count, so a full FIFO never bypasses.
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 20,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     wdata_i,
  output logic [W-1:0]     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             ready_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ready_o = (count_q != CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ready_o & ~flush_i;
  assign do_pop  = pop_i & (count_q != '0) & ~flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; count and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmit side: per-source result FIFOs feeding a round-robin grant
// of up to NUM_LANES sources per cycle onto registered broadcast lanes.
module cdb_broadcaster #(
  parameter int NUM_SRC    = 6,
  parameter int NUM_LANES  = ooo_pkg::NUM_LANES,
  parameter int ROB_IDX_W  = ooo_pkg::ROB_IDX_W,
  parameter int DATA_W     = ooo_pkg::DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_SRC-1:0]             fu_valid,
  output logic [NUM_SRC-1:0]             fu_ready,
  input  logic [NUM_SRC*ROB_IDX_W-1:0]   fu_rob_index,
  input  logic [NUM_SRC*DATA_W-1:0]      fu_result,
  output logic                           cdb_valid     [0:NUM_LANES-1],
  output logic [ROB_IDX_W-1:0]           cdb_rob_index [0:NUM_LANES-1],
  output logic [DATA_W-1:0]              cdb_result    [0:NUM_LANES-1]
);

  import ooo_pkg::*;

  localparam int ENT_W  = ROB_IDX_W + DATA_W;
  localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  logic [ENT_W-1:0]   head  [NUM_SRC];
  logic [CNT_W-1:0]   count [NUM_SRC];
  logic [NUM_SRC-1:0] nonempty;
  logic [NUM_SRC-1:0] pop;
  cdb_lane_t          lane_q [NUM_LANES];
  cdb_lane_t          lane_d [NUM_LANES];
  logic [SRC_W-1:0]   rr_q, rr_d;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (ENT_W)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .push_i  (fu_valid[gi]),
      .pop_i   (pop[gi]),
      .wdata_i ({fu_rob_index[gi*ROB_IDX_W +: ROB_IDX_W], fu_result[gi*DATA_W +: DATA_W]}),
      .head_o  (head[gi]),
      .count_o (count[gi]),
      .ready_o (fu_ready[gi])
    );
    assign nonempty[gi] = (count[gi] != '0);
  end

  // Scan from rr; the k-th non-empty source lands on lane k. Data of idle lanes holds.
  always_comb begin
    int n;
    int idx;
    n    = 0;
    idx  = 0;
    pop  = '0;
    rr_d = rr_q;
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_d[l]       = lane_q[l];
      lane_d[l].valid = 1'b0;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (nonempty[idx[SRC_W-1:0]] && n < NUM_LANES) begin
        pop[idx[SRC_W-1:0]]              = 1'b1;
        lane_d[n[LANE_W-1:0]].valid      = 1'b1;
        lane_d[n[LANE_W-1:0]].rob_index  = head[idx[SRC_W-1:0]][ENT_W-1:DATA_W];
        lane_d[n[LANE_W-1:0]].result     = head[idx[SRC_W-1:0]][DATA_W-1:0];
        rr_d = (idx == NUM_SRC - 1) ? '0 : SRC_W'(idx + 1);
        n    = n + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
      for (int l = 0; l < NUM_LANES; l++) lane_q[l] <= '0;
    end else if (flush) begin
      rr_q <= '0;
      for (int l = 0; l < NUM_LANES; l++) lane_q[l].valid <= 1'b0;
    end else begin
      rr_q <= rr_d;
      for (int l = 0; l < NUM_LANES; l++) lane_q[l] <= lane_d[l];
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign cdb_valid[gi]     = lane_q[gi].valid;
    assign cdb_rob_index[gi] = lane_q[gi].rob_index;
    assign cdb_result[gi]    = lane_q[gi].result;
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster with a per-source queue scoreboard
// that predicts the round-robin lane assignment each cycle.
module tb_cdb_broadcaster;

  localparam int NS = 6;
  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [NS-1:0] fu_valid;
  logic [NS-1:0] fu_ready;
  logic [NS*4-1:0]  fu_rob_index;
  logic [NS*16-1:0] fu_result;
  logic          cdb_valid     [0:NL-1];
  logic [3:0]    cdb_rob_index [0:NL-1];
  logic [15:0]   cdb_result    [0:NL-1];

  int checks    = 0;
  int failures  = 0;
  int bcast_cnt = 0;

  logic [19:0] mq [NS][$];
  logic        exp_v   [NL];
  logic [3:0]  exp_rob [NL];
  logic [15:0] exp_res [NL];
  int          mrr;

  cdb_broadcaster dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .fu_valid      (fu_valid),
    .fu_ready      (fu_ready),
    .fu_rob_index  (fu_rob_index),
    .fu_result     (fu_result),
    .cdb_valid     (cdb_valid),
    .cdb_rob_index (cdb_rob_index),
    .cdb_result    (cdb_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic [3:0] rob, input logic [15:0] data);
    fu_valid[s]            = 1'b1;
    fu_rob_index[s*4 +: 4] = rob;
    fu_result[s*16 +: 16]  = data;
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) mq[s].delete();
    mrr = 0;
    for (int l = 0; l < NL; l++) begin
      exp_v[l]   = 1'b0;
      exp_rob[l] = '0;
      exp_res[l] = '0;
    end
  endtask

  // One clock: predict from pre-edge state and inputs, then compare after the edge.
  task automatic tick();
    logic [NS-1:0] rdy;
    logic [19:0]   hd;
    int n;
    int idx;
    int last;
    n    = 0;
    last = 0;
    for (int s = 0; s < NS; s++) rdy[s] = (mq[s].size() != 2);
    chk("fu_ready", 32'(fu_ready), 32'(rdy));
    if (rst) begin
      model_reset();
    end else if (flush) begin
      for (int s = 0; s < NS; s++) mq[s].delete();
      mrr = 0;
      for (int l = 0; l < NL; l++) exp_v[l] = 1'b0;
    end else begin
      for (int l = 0; l < NL; l++) exp_v[l] = 1'b0;
      for (int i = 0; i < NS; i++) begin
        idx = (mrr + i) % NS;
        if (mq[idx].size() != 0 && n < NL) begin
          hd         = mq[idx].pop_front();
          exp_v[n]   = 1'b1;
          exp_rob[n] = hd[19:16];
          exp_res[n] = hd[15:0];
          last       = idx;
          n++;
        end
      end
      if (n > 0) mrr = (last + 1) % NS;
      for (int s = 0; s < NS; s++)
        if (fu_valid[s] && rdy[s]) mq[s].push_back({fu_rob_index[s*4 +: 4], fu_result[s*16 +: 16]});
    end
    @(posedge clk);
    #1;
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("lane%0d_valid", l), 32'(cdb_valid[l]), 32'(exp_v[l]));
      chk($sformatf("lane%0d_rob", l), 32'(cdb_rob_index[l]), 32'(exp_rob[l]));
      chk($sformatf("lane%0d_result", l), 32'(cdb_result[l]), 32'(exp_res[l]));
      if (cdb_valid[l] === 1'b1) bcast_cnt++;
    end
    chk("rr", 32'(dut.rr_q), 32'(mrr));
    $display("cycle t=%0t valid=%b%b%b%b rob0=%0d res0=%h rr=%0d ready=%b",
             $time, cdb_valid[0], cdb_valid[1], cdb_valid[2], cdb_valid[3],
             cdb_rob_index[0], cdb_result[0], dut.rr_q, fu_ready);
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    fu_valid     = '0;
    fu_rob_index = '0;
    fu_result    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Reset state
    chk("reset_ready", 32'(fu_ready), 32'h3f);
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("reset_lane%0d_valid", l), 32'(cdb_valid[l]), 32'h0);
      chk($sformatf("reset_lane%0d_result", l), 32'(cdb_result[l]), 32'h0);
    end
    chk("reset_rr", 32'(dut.rr_q), 32'h0);

    // 1: single push from source 2, two-edge latency
    drive(2, 4'd5, 16'h1234);
    tick();
    fu_valid = '0;
    chk("t1_not_yet", 32'(cdb_valid[0]), 32'h0);
    tick();
    chk("t1_valid", 32'(cdb_valid[0]), 32'h1);
    chk("t1_rob", 32'(cdb_rob_index[0]), 32'd5);
    chk("t1_result", 32'(cdb_result[0]), 32'h1234);
    chk("t1_lane1", 32'(cdb_valid[1]), 32'h0);
    chk("t1_rr", 32'(dut.rr_q), 32'd3);
    tick();
    chk("t1_one_cycle", 32'(cdb_valid[0]), 32'h0);

    // 2: all six sources at once from rr=0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int s = 0; s < NS; s++) drive(s, 4'(s + 8), 16'hA000 + 16'(s));
    tick();
    fu_valid = '0;
    tick();
    for (int k = 0; k < NL; k++) chk($sformatf("t2_first_lane%0d", k), 32'(cdb_rob_index[k]), 32'(k + 8));
    tick();
    chk("t2_second_lane0", 32'(cdb_rob_index[0]), 32'd12);
    chk("t2_second_lane1", 32'(cdb_rob_index[1]), 32'd13);
    chk("t2_second_lane2", 32'(cdb_valid[2]), 32'h0);
    chk("t2_rr", 32'(dut.rr_q), 32'd0);

    // 3: source 1 streams every cycle
    for (int k = 0; k < 8; k++) begin
      drive(1, 4'(k), 16'hB000 + 16'(k));
      tick();
      chk("t3_ready", 32'(fu_ready[1]), 32'h1);
    end
    fu_valid = '0;
    tick();
    chk("t3_last", 32'(cdb_result[0]), 32'hB007);
    tick();

    // 4: two pushes per source, then a rejected third push on the full ones
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bcast_cnt = 0;
    for (int s = 0; s < NS; s++) drive(s, 4'(s), 16'hC000 + 16'(s));
    tick();
    for (int s = 0; s < NS; s++) drive(s, 4'(s + 8), 16'hC100 + 16'(s));
    tick();
    chk("t4_ready", 32'(fu_ready), 32'h0f);
    fu_valid = '0;
    drive(4, 4'd15, 16'hD004);
    drive(5, 4'd15, 16'hD005);
    tick();
    fu_valid = '0;
    repeat (4) tick();
    chk("t4_bcast_total", 32'(bcast_cnt), 32'd12);

    // 5: flush with buffered results and a concurrent push
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 4'd1, 16'hF000);
    drive(1, 4'd2, 16'hF001);
    drive(2, 4'd3, 16'hF002);
    tick();
    fu_valid = '0;
    flush    = 1'b1;
    drive(3, 4'd4, 16'hF003);
    tick();
    chk("t5_no_valid", 32'(cdb_valid[0]), 32'h0);
    flush    = 1'b0;
    fu_valid = '0;
    bcast_cnt = 0;
    repeat (3) tick();
    chk("t5_nothing_leaks", 32'(bcast_cnt), 32'h0);
    chk("t5_ready", 32'(fu_ready), 32'h3f);

    // 6: reset mid-stream with lanes active
    for (int s = 0; s < NS; s++) drive(s, 4'(s), 16'hE000 + 16'(s));
    tick();
    fu_valid = '0;
    tick();
    chk("t6_active", 32'(cdb_valid[0]), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int l = 0; l < NL; l++) chk($sformatf("t6_lane%0d_cleared", l), 32'(cdb_valid[l]), 32'h0);
    chk("t6_rr", 32'(dut.rr_q), 32'h0);
    chk("t6_ready", 32'(fu_ready), 32'h3f);
    drive(4, 4'd9, 16'h4444);
    tick();
    fu_valid = '0;
    tick();
    chk("t6_valid", 32'(cdb_valid[0]), 32'h1);
    chk("t6_rob", 32'(cdb_rob_index[0]), 32'd9);
    chk("t6_result", 32'(cdb_result[0]), 32'h4444);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
